// File: rtl/pipe_pkg.sv
// pipe_pkg: shared opcode map, stage record and instruction-class helpers for pipe_ctrl.
package pipe_pkg;

  localparam logic [2:0] OP_SET   = 3'b000;
  localparam logic [2:0] OP_LDPX  = 3'b001;
  localparam logic [2:0] OP_MODEX = 3'b010;
  localparam logic [2:0] OP_STPX  = 3'b011;
  localparam logic [2:0] OP_CMPEQ = 3'b100;
  localparam logic [2:0] OP_JEQ   = 3'b101;
  localparam logic [2:0] OP_J     = 3'b110;
  localparam logic [2:0] OP_ADD   = 3'b111;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  // One in-flight instruction. Operand fields only matter while the entry sits in EX.
  typedef struct packed {
    logic       valid;
    logic       wr;
    logic [2:0] dest;
    logic       is_load;
    logic       is_mem;
    logic       is_st;
    logic       is_jmp;
    logic       use_a;
    logic [2:0] reg_a;
    logic       use_b;
    logic [2:0] reg_b;
  } stage_ent_t;

  function automatic logic is_writer(input logic [2:0] op);
    return op inside {OP_SET, OP_LDPX, OP_MODEX, OP_CMPEQ, OP_ADD};
  endfunction

  function automatic logic is_load(input logic [2:0] op);
    return op == OP_LDPX;
  endfunction

  function automatic logic is_mem_op(input logic [2:0] op);
    return op inside {OP_LDPX, OP_STPX};
  endfunction

  function automatic logic is_jump(input logic [2:0] op);
    return op inside {OP_J, OP_JEQ};
  endfunction

  function automatic logic uses_a(input logic [2:0] op);
    return op inside {OP_LDPX, OP_MODEX, OP_STPX, OP_CMPEQ, OP_ADD};
  endfunction

  function automatic logic uses_b(input logic [2:0] op);
    return op inside {OP_MODEX, OP_CMPEQ, OP_STPX};
  endfunction

  // Build the tracking record for the instruction currently in ID; invalid gives a bubble.
  function automatic stage_ent_t decode_id(input logic       valid,
                                           input logic [2:0] op,
                                           input logic [2:0] src1,
                                           input logic [2:0] src2,
                                           input logic [2:0] srcdest);
    stage_ent_t ent;
    ent = '0;
    if (valid) begin
      ent.valid   = 1'b1;
      ent.wr      = is_writer(op);
      ent.dest    = srcdest;
      ent.is_load = is_load(op);
      ent.is_mem  = is_mem_op(op);
      ent.is_st   = (op == OP_STPX);
      ent.is_jmp  = is_jump(op);
      ent.use_a   = uses_a(op);
      ent.reg_a   = src1;
      ent.use_b   = uses_b(op);
      // STPX carries its store data in the srcdest field.
      ent.reg_b   = (op == OP_STPX) ? srcdest : src2;
    end
    return ent;
  endfunction

  // True when cons reads a register that prod will write.
  function automatic logic raw_dep(input stage_ent_t prod, input stage_ent_t cons);
    logic hit;
    hit = (cons.use_a && (cons.reg_a == prod.dest)) || (cons.use_b && (cons.reg_b == prod.dest));
    return prod.valid && prod.wr && cons.valid && hit;
  endfunction

  // Operand source for EX; the younger MEM result wins over WB.
  function automatic fwd_sel_t fwd_pick(input logic       use_reg,
                                        input logic [2:0] r,
                                        input stage_ent_t mem_e,
                                        input stage_ent_t wb_e);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (use_reg) begin
      if (mem_e.valid && mem_e.wr && (mem_e.dest == r)) begin
        sel = FWD_MEM;
      end else if (wb_e.valid && wb_e.wr && (wb_e.dest == r)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_track.sv
// pipe_track: EX/MEM/WB in-flight instruction records with advance and bubble insertion.
module pipe_track
  import pipe_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       advance_i,
  input  logic       bubble_i,
  input  stage_ent_t id_ent_i,
  output stage_ent_t ex_o,
  output stage_ent_t mem_o,
  output stage_ent_t wb_o
);

  stage_ent_t ex_q, ex_d;
  stage_ent_t mem_q, mem_d;
  stage_ent_t wb_q, wb_d;

  // Shift the records one stage on advance; hold everything while frozen.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (advance_i) begin
      ex_d  = bubble_i ? '0 : id_ent_i;
      mem_d = ex_q;
      wb_d  = mem_q;
    end
  end

  // Stage record registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ex_o  = ex_q;
  assign mem_o = mem_q;
  assign wb_o  = wb_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stage enables, flushes, PC control and data-memory handshake for the 5-stage core.
// Define PIPE_CTRL_FWD_EN to enable operand forwarding; only load-use then stalls.
module pipe_ctrl
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [2:0] id_opcode,
  input  logic [2:0] id_src1,
  input  logic [2:0] id_src2,
  input  logic [2:0] id_srcdest,
  input  logic       ex_taken,
  input  logic       mem_ack,
  output logic       pc_en,
  output logic       pc_load,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_en,
  output logic       idex_flush,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e     state_q, state_d;
  stage_ent_t id_ent, ex_ent, mem_ent, wb_ent;
  logic       freeze;
  logic       jump;
  logic       hazard;

  assign id_ent = decode_id(id_valid, id_opcode, id_src1, id_src2, id_srcdest);

  pipe_track u_track (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .advance_i (~freeze),
    .bubble_i  (idex_flush),
    .id_ent_i  (id_ent),
    .ex_o      (ex_ent),
    .mem_o     (mem_ent),
    .wb_o      (wb_ent)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, memory handshake and pipeline freeze.
  always_comb begin
    state_d = state_q;
    freeze  = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      StRun: begin
        // The cycle a memory op lands in MEM is spent launching the request.
        if (mem_ent.valid && mem_ent.is_mem) begin
          state_d = StMemWait;
          freeze  = 1'b1;
        end
      end
      StMemWait: begin
        mem_req = 1'b1;
        mem_we  = mem_ent.is_st;
        if (mem_ack) begin
          state_d = StRun;
        end else begin
          freeze = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  assign jump = ex_ent.valid && ex_ent.is_jmp && ex_taken;

`ifdef PIPE_CTRL_FWD_EN
  // Only a load still in EX cannot be forwarded in time.
  assign hazard = ex_ent.is_load && raw_dep(ex_ent, id_ent);
  assign fwd_a  = fwd_pick(ex_ent.use_a, ex_ent.reg_a, mem_ent, wb_ent);
  assign fwd_b  = fwd_pick(ex_ent.use_b, ex_ent.reg_b, mem_ent, wb_ent);
`else
  // Write-before-read regfile covers WB; EX and MEM writers must drain first.
  assign hazard = raw_dep(ex_ent, id_ent) || raw_dep(mem_ent, id_ent);
  assign fwd_a  = FWD_RF;
  assign fwd_b  = FWD_RF;
`endif

  // Stage controls: memory freeze beats a taken jump, which beats a hazard stall.
  always_comb begin
    pc_en      = 1'b1;
    pc_load    = 1'b0;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    if (freeze) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (jump) begin
      pc_load    = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (hazard) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Record fields not consumed in every build configuration.
  logic unused_ent;
  assign unused_ent = ^{ex_ent, mem_ent, wb_ent};

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl; a cycle model pushes expected controls per cycle.
// Honours PIPE_CTRL_FWD_EN the same way the design does.
module tb_pipe_ctrl;
  import pipe_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [2:0] id_opcode, id_src1, id_src2, id_srcdest;
  logic       ex_taken, mem_ack;
  logic       pc_en, pc_load, ifid_en, ifid_flush, idex_en, idex_flush;
  logic       exmem_en, memwb_en, mem_req, mem_we;
  logic [1:0] fwd_a, fwd_b;

  pipe_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_opcode  (id_opcode),
    .id_src1    (id_src1),
    .id_src2    (id_src2),
    .id_srcdest (id_srcdest),
    .ex_taken   (ex_taken),
    .mem_ack    (mem_ack),
    .pc_en      (pc_en),
    .pc_load    (pc_load),
    .ifid_en    (ifid_en),
    .ifid_flush (ifid_flush),
    .idex_en    (idex_en),
    .idex_flush (idex_flush),
    .exmem_en   (exmem_en),
    .memwb_en   (memwb_en),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit [2:0] op;
    bit [2:0] s1;
    bit [2:0] s2;
    bit [2:0] sd;
    bit       tk;
  } ins_t;

  typedef struct {
    logic [9:0] ctl;
    logic [3:0] fwd;
  } exp_t;

  // {pc_en, pc_load, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, req, we}
  localparam logic [9:0] CtlReset = 10'b1010101100;

`ifdef PIPE_CTRL_FWD_EN
  localparam int ExpRawStalls = 0;
  localparam int ExpLuStalls  = 1;
`else
  localparam int ExpRawStalls = 2;
  localparam int ExpLuStalls  = 2;
`endif

  int   n_checks;
  int   n_errors;
  exp_t exp_q[$];
  ins_t prog_q[$];

  // Reference model state.
  ins_t m_ex, m_mem, m_wb;
  bit   m_wait;
  bit   m_flush_bub;
  int   wait_cnt;
  int   ack_lat;

  // Observation counters per scenario.
  int         obs_stall, obs_frozen, obs_req, obs_we, obs_load, obs_load_pcen, obs_load_wait;
  logic [3:0] obs_fwd_mask;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] dut_ctl();
    return {pc_en, pc_load, ifid_en, ifid_flush, idex_en, idex_flush,
            exmem_en, memwb_en, mem_req, mem_we};
  endfunction

  function automatic bit writes(bit [2:0] op);
    return op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b111};
  endfunction

  function automatic bit mem_class(bit [2:0] op);
    return op inside {3'b001, 3'b011};
  endfunction

  function automatic bit a_used(bit [2:0] op);
    return op inside {3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
  endfunction

  function automatic bit dep(ins_t p, ins_t c);
    bit hit_a, hit_b;
    hit_a = a_used(c.op) && (c.s1 == p.sd);
    hit_b = ((c.op inside {3'b010, 3'b100}) && (c.s2 == p.sd)) || ((c.op == 3'b011) && (c.sd == p.sd));
    return p.v && writes(p.op) && c.v && (hit_a || hit_b);
  endfunction

  function automatic bit [1:0] fwd_of(bit used, bit [2:0] r);
    if (!used) return 2'b00;
    if (m_mem.v && writes(m_mem.op) && (m_mem.sd == r)) return 2'b01;
    if (m_wb.v && writes(m_wb.op) && (m_wb.sd == r)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic ins_t mk(bit [2:0] op, bit [2:0] s1, bit [2:0] s2, bit [2:0] sd, bit tk);
    ins_t t;
    t.v = 1'b1; t.op = op; t.s1 = s1; t.s2 = s2; t.sd = sd; t.tk = tk;
    return t;
  endfunction

  task automatic clr_obs();
    obs_stall = 0; obs_frozen = 0; obs_req = 0; obs_we = 0;
    obs_load = 0; obs_load_pcen = 0; obs_load_wait = 0; obs_fwd_mask = '0;
  endtask

  task automatic model_clear();
    m_ex = '{default: 0};
    m_mem = '{default: 0};
    m_wb = '{default: 0};
    m_wait = 1'b0;
    m_flush_bub = 1'b0;
    wait_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    id_valid = 1'b0; id_opcode = '0; id_src1 = '0; id_src2 = '0; id_srcdest = '0;
    ex_taken = 1'b0; mem_ack = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    #2;
    check_eq("rst_ctl", 32'(dut_ctl()), 32'(CtlReset));
    check_eq("rst_fwd", 32'({fwd_a, fwd_b}), 0);
    rst_n = 1'b1;
  endtask

  // Scoreboard consumer: compare each cycle's expectation mid low phase.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq($sformatf("ctl@%0t", $time), 32'(dut_ctl()), 32'(e.ctl));
      check_eq($sformatf("fwd@%0t", $time), 32'({fwd_a, fwd_b}), 32'(e.fwd));
    end
  end

  // Drive the program one cycle at a time, pushing the model's expected controls.
  task automatic run(input string name, input int max_cycles, input bit must_drain);
    int cyc;
    cyc = 0;
    while ((prog_q.size() > 0 || m_ex.v || m_mem.v || m_wb.v || m_wait) && cyc < max_cycles) begin
      ins_t id;
      bit   tk, ack, frz, jmp, hz, stl, st;
      exp_t e;
      @(negedge clk);
      id = '{default: 0};
      id.op = 3'($urandom_range(0, 7));
      id.s1 = 3'($urandom_range(0, 7));
      id.s2 = 3'($urandom_range(0, 7));
      id.sd = 3'($urandom_range(0, 7));
      if (!m_flush_bub && prog_q.size() > 0) id = prog_q[0];
      tk  = m_ex.v && ((m_ex.op == 3'b110) || ((m_ex.op == 3'b101) && m_ex.tk));
      ack = m_wait ? (wait_cnt >= ack_lat) : 1'($urandom_range(0, 1));
      id_valid = id.v; id_opcode = id.op; id_src1 = id.s1; id_src2 = id.s2; id_srcdest = id.sd;
      ex_taken = tk;
      mem_ack  = ack;

      frz = m_wait ? !ack : (m_mem.v && mem_class(m_mem.op));
      jmp = !frz && tk;
`ifdef PIPE_CTRL_FWD_EN
      hz = (m_ex.op == 3'b001) && dep(m_ex, id);
`else
      hz = dep(m_ex, id) || dep(m_mem, id);
`endif
      stl = !frz && !jmp && hz;
      st  = m_wait && (m_mem.op == 3'b011);
      if (frz) e.ctl = {8'b0, m_wait, st};
      else     e.ctl = {!stl, jmp, !stl, jmp, 1'b1, jmp || stl, 1'b1, 1'b1, m_wait, st};
`ifdef PIPE_CTRL_FWD_EN
      e.fwd = {fwd_of(m_ex.v && a_used(m_ex.op), m_ex.s1),
               fwd_of(m_ex.v && (m_ex.op inside {3'b010, 3'b100, 3'b011}),
                      (m_ex.op == 3'b011) ? m_ex.sd : m_ex.s2)};
`else
      e.fwd = 4'b0000;
`endif
      exp_q.push_back(e);

      #2;
      if (idex_flush && !pc_load && !pc_en) obs_stall++;
      if (!pc_en && !ifid_en && !idex_en && !exmem_en && !memwb_en) obs_frozen++;
      if (mem_req) obs_req++;
      if (mem_we) obs_we++;
      if (pc_load) obs_load++;
      if (pc_load && pc_en) obs_load_pcen++;
      if (pc_load && mem_req) obs_load_wait++;
      obs_fwd_mask[fwd_a] = 1'b1;

      @(posedge clk);
      if (m_wait) begin
        wait_cnt++;
        m_wait = !ack;
      end else if (frz) begin
        m_wait = 1'b1;
        wait_cnt = 0;
      end
      if (!frz) begin
        m_wb  = m_mem;
        m_mem = m_ex;
        if (jmp || stl) m_ex = '{default: 0};
        else            m_ex = id;
        if (m_flush_bub) m_flush_bub = 1'b0;
        else if (prog_q.size() > 0 && !stl) void'(prog_q.pop_front());
        if (jmp) m_flush_bub = 1'b1;
      end
      cyc++;
    end
    if (must_drain) begin
      check_eq({name, "_drain"},
               32'(prog_q.size() > 0 || m_ex.v || m_mem.v || m_wb.v || m_wait), 0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    ack_lat  = 0;
    clr_obs();
    do_reset();

    // ADD r1 then MODEX r2 <- r1, r3.
    clr_obs(); ack_lat = 0;
    prog_q.push_back(mk(3'b111, 3'd0, 3'd0, 3'd1, 1'b0));
    prog_q.push_back(mk(3'b010, 3'd1, 3'd3, 3'd2, 1'b0));
    run("raw", 50, 1'b1);
    check_eq("raw_stalls", obs_stall, ExpRawStalls);
`ifdef PIPE_CTRL_FWD_EN
    check_eq("raw_fwd_mem", 32'(obs_fwd_mask[1]), 1);
`else
    check_eq("raw_fwd_none", 32'(obs_fwd_mask), 1);
`endif

    // LDPX r4 then ADD r5 <- r4.
    clr_obs(); ack_lat = 0;
    prog_q.push_back(mk(3'b001, 3'd6, 3'd0, 3'd4, 1'b0));
    prog_q.push_back(mk(3'b111, 3'd4, 3'd0, 3'd5, 1'b0));
    run("lu", 50, 1'b1);
    check_eq("lu_stalls", obs_stall, ExpLuStalls);
`ifdef PIPE_CTRL_FWD_EN
    check_eq("lu_fwd_wb", 32'(obs_fwd_mask[2]), 1);
`endif

    // STPX with ack held low for three MEM_WAIT cycles.
    clr_obs(); ack_lat = 3;
    prog_q.push_back(mk(3'b011, 3'd2, 3'd0, 3'd5, 1'b0));
    run("st", 50, 1'b1);
    check_eq("st_req", obs_req, 4);
    check_eq("st_we", obs_we, 4);
    check_eq("st_frozen", obs_frozen, 4);

    // J in EX while the ID instruction has a hazard; MODEX is discarded, SET is the target.
    clr_obs(); ack_lat = 0;
    prog_q.push_back(mk(3'b111, 3'd0, 3'd0, 3'd1, 1'b0));
    prog_q.push_back(mk(3'b110, 3'd0, 3'd0, 3'd0, 1'b0));
    prog_q.push_back(mk(3'b010, 3'd1, 3'd1, 3'd3, 1'b0));
    prog_q.push_back(mk(3'b000, 3'd0, 3'd0, 3'd7, 1'b0));
    run("j", 50, 1'b1);
    check_eq("j_load", obs_load, 1);
    check_eq("j_load_pcen", obs_load_pcen, 1);
    check_eq("j_stalls", obs_stall, 0);

    // JEQ taken in EX while LDPX sits in MEM: freeze, then jump in the ack cycle.
    clr_obs(); ack_lat = 1;
    prog_q.push_back(mk(3'b001, 3'd2, 3'd0, 3'd5, 1'b0));
    prog_q.push_back(mk(3'b101, 3'd0, 3'd0, 3'd0, 1'b1));
    prog_q.push_back(mk(3'b111, 3'd5, 3'd0, 3'd6, 1'b0));
    prog_q.push_back(mk(3'b000, 3'd0, 3'd0, 3'd6, 1'b0));
    run("jeq", 50, 1'b1);
    check_eq("jeq_load", obs_load, 1);
    check_eq("jeq_load_in_wait", obs_load_wait, 1);
    check_eq("jeq_frozen", obs_frozen, 2);

    // Random programs with gaps, taken/not-taken JEQ and varying ack latency.
    for (int r = 0; r < 3; r++) begin
      clr_obs();
      ack_lat = r;
      for (int i = 0; i < 60; i++) begin
        ins_t t;
        t = mk(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        t.v = ($urandom_range(0, 6) != 0);
        prog_q.push_back(t);
      end
      run($sformatf("rnd%0d", r), 600, 1'b1);
    end

    // Reset asserted mid MEM_WAIT.
    clr_obs(); ack_lat = 100;
    prog_q.push_back(mk(3'b011, 3'd1, 3'd0, 3'd2, 1'b0));
    run("rstwait", 4, 1'b0);
    #1;
    check_eq("rstwait_req_before", 32'(mem_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstwait_req_after", 32'(mem_req), 0);
    check_eq("rstwait_ctl", 32'(dut_ctl()), 32'(CtlReset));
    check_eq("rstwait_fwd", 32'({fwd_a, fwd_b}), 0);
    prog_q.delete();
    do_reset();

    // Normal operation resumes after reset.
    clr_obs(); ack_lat = 0;
    prog_q.push_back(mk(3'b111, 3'd0, 3'd0, 3'd1, 1'b0));
    prog_q.push_back(mk(3'b010, 3'd1, 3'd3, 3'd2, 1'b0));
    run("post", 50, 1'b1);
    check_eq("post_stalls", obs_stall, ExpRawStalls);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
